// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shift type encodings and sequencer state enum shared by the shift datapath
package arm_pkg;

    localparam logic [1:0] SHIFT_LSL = 2'b00;
    localparam logic [1:0] SHIFT_LSR = 2'b01;
    localparam logic [1:0] SHIFT_ASR = 2'b10;
    localparam logic [1:0] SHIFT_ROR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } shift_state_t;

endpackage

// File: rtl/shift_step_unit.sv
// rtl/shift_step_unit.sv - combinational single-step shifter (k bits, k <= 8) with ARM carry-out
//   value_in/carry_in : current value and C flag
//   shift_type/rrx    : LSL/LSR/ASR/ROR, rrx selects 1-bit rotate through C (with ROR)
//   k                 : bits to shift this step; k=0 passes value and carry through
//   value_out/carry_out : shifted value and last bit shifted out
module shift_step_unit
    import arm_pkg::*;
(
    input  logic [31:0] value_in,
    input  logic        carry_in,
    input  logic [1:0]  shift_type,
    input  logic        rrx,
    input  logic [3:0]  k,
    output logic [31:0] value_out,
    output logic        carry_out
);

    logic [32:0]        lsl_w;
    logic [32:0]        lsr_w;
    logic signed [32:0] asr_src;
    logic signed [32:0] asr_w;
    logic [5:0]         ror_back;
    logic [31:0]        ror_v;

    // The extra bit beside the value catches the last bit shifted out,
    // so carry is simply that guard bit after the shift.
    assign lsl_w    = {1'b0, value_in} << k;
    assign lsr_w    = {value_in, 1'b0} >> k;
    assign asr_src  = {value_in, 1'b0};
    assign asr_w    = asr_src >>> k;
    assign ror_back = 6'd32 - {2'b00, k};
    assign ror_v    = (value_in >> k) | (value_in << ror_back);

    always_comb begin
        value_out = value_in;
        carry_out = carry_in;
        if (shift_type == SHIFT_ROR && rrx) begin
            value_out = {carry_in, value_in[31:1]};
            carry_out = value_in[0];
        end else if (k != 4'd0) begin
            case (shift_type)
                SHIFT_LSL: {carry_out, value_out} = lsl_w;
                SHIFT_LSR: {value_out, carry_out} = lsr_w;
                SHIFT_ASR: {value_out, carry_out} = asr_w;
                default: begin
                    value_out = ror_v;
                    carry_out = ror_v[31];
                end
            endcase
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-cycle register-amount shifter (LSL/LSR/ASR/ROR/RRX) with valid/ready handshakes
//   clk, rst_n             : clock, asynchronous active-low reset
//   in_valid/in_ready      : request handshake; in_ready only while idle
//   in_operand/in_amount   : Rm value and Rs[7:0]
//   in_type/in_rrx/in_carry: shift type, RRX select, current C flag
//   flush                  : synchronous abort back to idle
//   out_valid/out_ready    : result handshake; out_result/out_carry held until taken
module shift_sequencer
    import arm_pkg::*;
#(
    parameter int SHIFT_STEP = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_operand,
    input  logic [7:0]  in_amount,
    input  logic [1:0]  in_type,
    input  logic        in_rrx,
    input  logic        in_carry,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_carry
);

    localparam int CNT_W = 6;
    localparam logic [CNT_W-1:0] STEP_CNT = CNT_W'(SHIFT_STEP);

    shift_state_t     state;
    logic [1:0]       type_q;
    logic             rrx_q;
    logic [CNT_W-1:0] remaining;

    logic [CNT_W-1:0] eff;
    logic             accept_carry;
    logic [3:0]       step_k;
    logic [CNT_W-1:0] next_remaining;
    logic [31:0]      step_value;
    logic             step_carry;

    // Effective iteration count. The clamps at 33 (LSL/LSR) and 32 (ASR)
    // make the iterative shift land on the architectural result and carry
    // for large amounts without any special-casing later.
    always_comb begin
        eff          = '0;
        accept_carry = in_carry;
        if (in_type == SHIFT_ROR && in_rrx) begin
            eff = CNT_W'(1);
        end else if (in_amount != 8'd0) begin
            case (in_type)
                SHIFT_LSL, SHIFT_LSR: eff = (in_amount > 8'd33) ? CNT_W'(33) : in_amount[CNT_W-1:0];
                SHIFT_ASR:            eff = (in_amount > 8'd32) ? CNT_W'(32) : in_amount[CNT_W-1:0];
                default: begin
                    eff = {1'b0, in_amount[4:0]};
                    // Rotate by a nonzero multiple of 32: value unchanged, C = bit 31.
                    if (in_amount[4:0] == 5'd0) begin
                        accept_carry = in_operand[31];
                    end
                end
            endcase
        end
    end

    assign step_k         = (remaining < STEP_CNT) ? remaining[3:0] : 4'(SHIFT_STEP);
    assign next_remaining = remaining - CNT_W'(step_k);

    shift_step_unit u_step (
        .value_in   (out_result),
        .carry_in   (out_carry),
        .shift_type (type_q),
        .rrx        (rrx_q),
        .k          (step_k),
        .value_out  (step_value),
        .carry_out  (step_carry)
    );

    // out_result/out_carry double as the working registers; they only
    // matter to the consumer while out_valid is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_carry  <= 1'b0;
            type_q     <= SHIFT_LSL;
            rrx_q      <= 1'b0;
            remaining  <= '0;
        end else if (flush) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            remaining <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        out_result <= in_operand;
                        out_carry  <= accept_carry;
                        type_q     <= in_type;
                        rrx_q      <= in_rrx;
                        remaining  <= eff;
                        in_ready   <= 1'b0;
                        if (eff == '0) begin
                            state     <= ST_DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    out_result <= step_value;
                    out_carry  <= step_carry;
                    remaining  <= next_remaining;
                    if (next_remaining == '0) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - randomized and directed checks of shift_sequencer against an ARM shift model
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_operand = '0;
    logic [7:0]  in_amount = '0;
    logic [1:0]  in_type = '0;
    logic        in_rrx = 1'b0;
    logic        in_carry = 1'b0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic        out_carry;

    int vectors = 0;
    int miscompares = 0;

    shift_sequencer #(.SHIFT_STEP(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_operand (in_operand),
        .in_amount  (in_amount),
        .in_type    (in_type),
        .in_rrx     (in_rrx),
        .in_carry   (in_carry),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_carry  (out_carry)
    );

    always #5 clk = ~clk;

    // Architectural ARM barrel-shifter result computed in one go.
    task automatic model(input logic [31:0] op, input int amt, input logic [1:0] typ,
                         input logic rrx, input logic cin,
                         output logic [31:0] r, output logic c, output int lat);
        int eff;
        logic signed [31:0] s;
        int rot;
        s = op;
        r = op;
        c = cin;
        eff = 0;
        if (typ == 2'b11 && rrx) begin
            r = {cin, op[31:1]};
            c = op[0];
            eff = 1;
        end else if (amt != 0) begin
            case (typ)
                2'b00: begin
                    eff = (amt > 33) ? 33 : amt;
                    if (amt < 32) begin r = op << amt; c = op[32-amt]; end
                    else if (amt == 32) begin r = 0; c = op[0]; end
                    else begin r = 0; c = 1'b0; end
                end
                2'b01: begin
                    eff = (amt > 33) ? 33 : amt;
                    if (amt < 32) begin r = op >> amt; c = op[amt-1]; end
                    else if (amt == 32) begin r = 0; c = op[31]; end
                    else begin r = 0; c = 1'b0; end
                end
                2'b10: begin
                    eff = (amt > 32) ? 32 : amt;
                    if (amt < 32) begin r = s >>> amt; c = op[amt-1]; end
                    else begin r = {32{op[31]}}; c = op[31]; end
                end
                default: begin
                    rot = amt % 32;
                    eff = rot;
                    if (rot == 0) begin r = op; c = op[31]; end
                    else begin r = (op >> rot) | (op << (32 - rot)); c = op[rot-1]; end
                end
            endcase
        end
        lat = (eff + 3) / 4;
    endtask

    // Presents one request, waits for acceptance and result; optionally takes the result.
    task automatic do_op(input logic [31:0] op, input logic [7:0] amt, input logic [1:0] typ,
                         input logic rrx, input logic cin, input bit drain,
                         output logic [31:0] res, output logic c, output int lat, output bit ok);
        int bound;
        ok = 1'b1;
        in_operand = op;
        in_amount = amt;
        in_type = typ;
        in_rrx = rrx;
        in_carry = cin;
        in_valid = 1'b1;
        out_ready = 1'b0;
        bound = 0;
        while (!in_ready && bound < 50) begin
            @(posedge clk); #1;
            bound++;
        end
        if (!in_ready) ok = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) ok = 1'b0;
        res = out_result;
        c = out_carry;
        if (drain) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        vectors++;
        if (out_valid !== 1'b0 || out_result !== 32'h0 || out_carry !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got valid=%b result=%h carry=%b want 0/00000000/0",
                     out_valid, out_result, out_carry);
        end
        apply_reset();
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ready: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        logic [31:0] op_t[8] = '{32'h8000_0001, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                                 32'h0000_00F1, 32'h8000_0000, 32'h0000_0003, 32'h1234_5678};
        logic [7:0]  amt_t[8] = '{8'd1, 8'd32, 8'd40, 8'd200, 8'd36, 8'd32, 8'd0, 8'd0};
        logic [1:0]  typ_t[8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b11, 2'b11, 2'b11, 2'b00};
        logic        rrx_t[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic        cin_t[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [31:0] exp_r[8] = '{32'h0000_0002, 32'h0, 32'h0, 32'hFFFF_FFFF,
                                  32'h1000_000F, 32'h8000_0000, 32'h8000_0001, 32'h1234_5678};
        logic        exp_c[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        int          exp_l[8] = '{1, 8, 9, 8, 1, 0, 1, 0};
        logic [31:0] r;
        logic c;
        int lat;
        bit ok;
        for (int i = 0; i < 8; i++) begin
            do_op(op_t[i], amt_t[i], typ_t[i], rrx_t[i], cin_t[i], 1'b1, r, c, lat, ok);
            vectors++;
            if (!ok || r !== exp_r[i] || c !== exp_c[i] || lat !== exp_l[i]) begin
                miscompares++;
                $display("FAIL directed_%0d: got ok=%b result=%h carry=%b latency=%0d want result=%h carry=%b latency=%0d",
                         i, ok, r, c, lat, exp_r[i], exp_c[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] r;
        logic c;
        int lat;
        bit ok;
        do_op(32'h1234_5678, 8'd0, 2'b00, 1'b0, 1'b1, 1'b0, r, c, lat, ok);
        // A second request arrives while the result is held; it must be ignored.
        in_operand = 32'hDEAD_BEEF;
        in_amount = 8'd4;
        in_type = 2'b01;
        in_carry = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (!ok || out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== 32'h1234_5678 || out_carry !== 1'b1) begin
                miscompares++;
                $display("FAIL backpressure_hold_%0d: got valid=%b in_ready=%b result=%h carry=%b want 1/0/12345678/1",
                         i, out_valid, in_ready, out_result, out_carry);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL backpressure_release: got valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_flush();
        logic [31:0] r;
        logic c;
        int lat;
        bit ok;
        in_operand = 32'hFFFF_0000;
        in_amount = 8'd40;
        in_type = 2'b01;
        in_rrx = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_mid_shift: got valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
        repeat (10) @(posedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_stays_idle: got valid=%b want 0", out_valid);
        end
        // Flush coinciding with a request: the request must not be taken.
        in_operand = 32'h0000_0001;
        in_amount = 8'd0;
        in_type = 2'b00;
        in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_beats_accept: got valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
        do_op(32'h8000_0000, 8'd32, 2'b01, 1'b0, 1'b0, 1'b1, r, c, lat, ok);
        vectors++;
        if (!ok || r !== 32'h0 || c !== 1'b1 || lat !== 8) begin
            miscompares++;
            $display("FAIL flush_recover: got ok=%b result=%h carry=%b latency=%0d want 00000000/1/8", ok, r, c, lat);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r;
        logic c;
        int lat;
        bit ok;
        in_operand = 32'h8000_0000;
        in_amount = 8'd200;
        in_type = 2'b10;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_mid_shift: got valid=%b in_ready=%b result=%h want 0/1/00000000",
                     out_valid, in_ready, out_result);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(32'h8000_0001, 8'd1, 2'b00, 1'b0, 1'b0, 1'b1, r, c, lat, ok);
        vectors++;
        if (!ok || r !== 32'h2 || c !== 1'b1 || lat !== 1) begin
            miscompares++;
            $display("FAIL reset_recover: got ok=%b result=%h carry=%b latency=%0d want 00000002/1/1", ok, r, c, lat);
        end
    endtask

    task automatic test_random();
        logic [31:0] op, r, er;
        logic [7:0] amt;
        logic [1:0] typ;
        logic rrx, cin, c, ec;
        int lat, el;
        bit ok;
        for (int n = 0; n < 80; n++) begin
            op = $urandom;
            case ($urandom_range(0, 2))
                0: amt = 8'($urandom_range(0, 8));
                1: amt = 8'($urandom_range(28, 36));
                default: amt = 8'($urandom_range(0, 255));
            endcase
            typ = 2'($urandom_range(0, 3));
            rrx = (typ == 2'b11) && ($urandom_range(0, 3) == 0);
            cin = 1'($urandom_range(0, 1));
            model(op, int'(amt), typ, rrx, cin, er, ec, el);
            do_op(op, amt, typ, rrx, cin, 1'b1, r, c, lat, ok);
            vectors++;
            if (!ok || r !== er || c !== ec || lat !== el) begin
                miscompares++;
                $display("FAIL random_%0d op=%h amt=%0d type=%0d rrx=%b cin=%b: got ok=%b result=%h carry=%b latency=%0d want result=%h carry=%b latency=%0d",
                         n, op, amt, typ, rrx, cin, ok, r, c, lat, er, ec, el);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
